// File: rtl/mcbsp_pkg.sv
// Shared McBSP constants and state encoding for the frame master and its bench models.
package mcbsp_pkg;

  localparam int unsigned WORDS_PER_FRAME_DEF = 8;
  localparam int unsigned BITS_PER_WORD_DEF   = 32;
  localparam int unsigned NBITS               = WORDS_PER_FRAME_DEF * BITS_PER_WORD_DEF;
  localparam int unsigned CLK_DIV_DEF         = 4;
  localparam int unsigned IDLE_BITS_DEF       = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

endpackage

// File: rtl/mcbsp_master_controller_if.sv
// Host-side request/response bundle of the McBSP frame master.
interface mcbsp_master_controller_if
  import mcbsp_pkg::*;
#(
  parameter int unsigned FRAME_BITS = NBITS
) ();

  logic                  start;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  busy;
  logic                  overrun;
  logic [FRAME_BITS-1:0] dataset_read;
  logic                  rx_valid;

  // Host side issues requests and consumes results.
  modport master (
    output start, tx_data,
    input  busy, overrun, dataset_read, rx_valid
  );

  // Controller side.
  modport slave (
    input  start, tx_data,
    output busy, overrun, dataset_read, rx_valid
  );

endinterface

// File: rtl/mcbsp_bitclk_gen.sv
// Free-running McBSP bit clock with one-cycle rise/fall strobes aligned to the toggle.
module mcbsp_bitclk_gen
  import mcbsp_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic a_clk,
  input  logic a_reset,
  output logic mcbsp_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned      CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Half-period counter; the strobe is high in the cycle the new clock level appears.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      cnt       <= '0;
      mcbsp_clk <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        mcbsp_clk <= ~mcbsp_clk;
        rise_tick <= ~mcbsp_clk;
        fall_tick <= mcbsp_clk;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mcbsp_master_controller.sv
// McBSP frame master: drives bit clock, frame sync and tx data, captures the rx frame.
module mcbsp_master_controller
  import mcbsp_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
  parameter int unsigned BITS_PER_WORD   = BITS_PER_WORD_DEF,
  parameter int unsigned CLK_DIV         = CLK_DIV_DEF,
  parameter int unsigned IDLE_BITS       = IDLE_BITS_DEF
) (
  input  logic                     a_clk,
  input  logic                     a_reset,
  mcbsp_master_controller_if.slave host,
  output logic                     mcbsp_clk,
  output logic                     mcbsp_frame_start,
  output logic                     mcbsp_data_tx,
  input  logic                     mcbsp_data_rx
);

  localparam int unsigned FRAME_BITS  = WORDS_PER_FRAME * BITS_PER_WORD;
  localparam int unsigned FLUSH_FALLS = FRAME_BITS + IDLE_BITS;
  localparam int unsigned BIT_CNT_W   = $clog2(FRAME_BITS);
  localparam int unsigned FALL_CNT_W  = $clog2(FLUSH_FALLS);

  logic rise_tick;
  logic fall_tick;

  state_t                  state,    state_d;
  logic [FRAME_BITS-1:0]   tx_sh,    tx_sh_d;
  logic [FRAME_BITS-2:0]   rx_sh,    rx_sh_d;
  logic [BIT_CNT_W-1:0]    bit_cnt,  bit_cnt_d;
  logic [FALL_CNT_W-1:0]   fall_cnt, fall_cnt_d;
  logic                    pending,  pending_d;
  logic                    busy_d;
  logic                    overrun_d;
  logic                    fs_d;
  logic                    tx_d;
  logic [FRAME_BITS-1:0]   dataset_d;
  logic                    rx_valid_d;

  mcbsp_bitclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bitclk (
    .a_clk     (a_clk),
    .a_reset   (a_reset),
    .mcbsp_clk (mcbsp_clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // State and datapath registers; reset parks in FLUSH so a slave cut off mid-frame can finish.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      state             <= ST_FLUSH;
      tx_sh             <= '0;
      rx_sh             <= '0;
      bit_cnt           <= '0;
      fall_cnt          <= FALL_CNT_W'(FLUSH_FALLS - 1);
      pending           <= 1'b0;
      host.busy         <= 1'b1;
      host.overrun      <= 1'b0;
      mcbsp_frame_start <= 1'b0;
      mcbsp_data_tx     <= 1'b0;
      host.dataset_read <= '0;
      host.rx_valid     <= 1'b0;
    end else begin
      state             <= state_d;
      tx_sh             <= tx_sh_d;
      rx_sh             <= rx_sh_d;
      bit_cnt           <= bit_cnt_d;
      fall_cnt          <= fall_cnt_d;
      pending           <= pending_d;
      host.busy         <= busy_d;
      host.overrun      <= overrun_d;
      mcbsp_frame_start <= fs_d;
      mcbsp_data_tx     <= tx_d;
      host.dataset_read <= dataset_d;
      host.rx_valid     <= rx_valid_d;
    end
  end

  // Next-state: request capture, frame sequencing on bit-clock strobes, idle/flush countdown.
  always_comb begin
    state_d    = state;
    tx_sh_d    = tx_sh;
    rx_sh_d    = rx_sh;
    bit_cnt_d  = bit_cnt;
    fall_cnt_d = fall_cnt;
    pending_d  = pending;
    overrun_d  = host.overrun;
    fs_d       = mcbsp_frame_start;
    tx_d       = mcbsp_data_tx;
    dataset_d  = host.dataset_read;
    rx_valid_d = 1'b0;

    // busy already covers the acceptance cycle because pending is still set there
    if (host.start) begin
      if (host.busy) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (rise_tick && pending) begin
          tx_sh_d   = host.tx_data;
          fs_d      = 1'b1;
          pending_d = 1'b0;
          state_d   = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (rise_tick) begin
          fs_d      = 1'b0;
          tx_d      = tx_sh[FRAME_BITS-1];
          tx_sh_d   = {tx_sh[FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = BIT_CNT_W'(FRAME_BITS - 1);
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (fall_tick) begin
          rx_sh_d = {rx_sh[FRAME_BITS-3:0], mcbsp_data_rx};
          if (bit_cnt == '0) begin
            dataset_d  = {rx_sh, mcbsp_data_rx};
            rx_valid_d = 1'b1;
            tx_d       = 1'b0;
            fall_cnt_d = FALL_CNT_W'(IDLE_BITS - 1);
            state_d    = ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt - BIT_CNT_W'(1);
          end
        end
        if (rise_tick) begin
          tx_d    = tx_sh[FRAME_BITS-1];
          tx_sh_d = {tx_sh[FRAME_BITS-2:0], 1'b0};
        end
      end

      ST_GAP, ST_FLUSH: begin
        tx_d = 1'b0;
        fs_d = 1'b0;
        if (fall_tick) begin
          if (fall_cnt == '0) begin
            state_d = ST_IDLE;
          end else begin
            fall_cnt_d = fall_cnt - FALL_CNT_W'(1);
          end
        end
      end

      default: begin
        tx_d       = 1'b0;
        fs_d       = 1'b0;
        fall_cnt_d = FALL_CNT_W'(FLUSH_FALLS - 1);
        state_d    = ST_FLUSH;
      end
    endcase

    busy_d = (state_d != ST_IDLE) | pending_d;
  end

endmodule

// File: tb/tb_mcbsp_master_controller.sv
// Scoreboard bench for the McBSP frame master: loopback, behavioural slave, overrun, reset flush.
module tb_mcbsp_master_controller;
  import mcbsp_pkg::*;

  localparam int unsigned FB         = NBITS;
  localparam int unsigned TB_CLK_DIV = 2;
  localparam int unsigned TB_IDLE    = 2;
  localparam int unsigned BIT_CYC    = 2 * TB_CLK_DIV;
  localparam int unsigned FRAME_BUD  = (FB + TB_IDLE + 40) * BIT_CYC;
  localparam int unsigned LB_DLY     = TB_CLK_DIV * 10 - 1;

  logic a_clk = 1'b0;
  logic a_reset;
  logic mcbsp_clk;
  logic fs;
  logic data_tx;
  logic data_rx;
  logic rx_sel;
  logic lb_rx;
  logic s_out = 1'b0;

  mcbsp_master_controller_if #(.FRAME_BITS(FB)) host ();

  mcbsp_master_controller #(
    .WORDS_PER_FRAME (8),
    .BITS_PER_WORD   (32),
    .CLK_DIV         (TB_CLK_DIV),
    .IDLE_BITS       (TB_IDLE)
  ) dut (
    .a_clk             (a_clk),
    .a_reset           (a_reset),
    .host              (host),
    .mcbsp_clk         (mcbsp_clk),
    .mcbsp_frame_start (fs),
    .mcbsp_data_tx     (data_tx),
    .mcbsp_data_rx     (data_rx)
  );

  always #5 a_clk = ~a_clk;

  assign data_rx = rx_sel ? s_out : lb_rx;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned rx_cnt = 0;
  int unsigned fs_rise_cnt = 0;
  int unsigned fs_len = 0;
  int unsigned fs_len_last = 0;
  int unsigned fall_cnt = 0;
  int unsigned fs_falls_hi = 0;
  int unsigned slave_done = 0;
  logic        fs_prev = 1'b0;

  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] slv_q[$];

  logic [FB-1:0] s_tx_word;
  logic [FB-1:0] s_tx_sh;
  logic [FB-1:0] s_rx;
  int unsigned   s_cnt = 0;
  logic          s_active = 1'b0;

  task automatic check(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] p = '0;
    for (int i = 0; i < 8; i++) p = {p[FB-33:0], 32'($urandom)};
    return p;
  endfunction

  // Output monitor: scoreboard pop on rx_valid, frame-sync length tracking.
  initial begin
    forever begin
      @(posedge a_clk);
      #1;
      if (host.rx_valid === 1'b1) begin
        rx_cnt++;
        check("rx_expected", FB'(exp_q.size() != 0), FB'(1));
        if (exp_q.size() != 0) check("rx_frame", host.dataset_read, exp_q.pop_front());
      end
      if (fs === 1'b1 && fs_prev !== 1'b1) begin
        fs_rise_cnt++;
        fs_len = 0;
      end
      if (fs === 1'b1) fs_len++;
      if (fs !== 1'b1 && fs_prev === 1'b1) fs_len_last = fs_len;
      fs_prev = fs;
    end
  end

  // Loopback path: tx echoed back just under half a bit period later.
  initial begin
    logic v;
    lb_rx = 1'b0;
    forever begin
      @(data_tx);
      v = data_tx;
      #(LB_DLY);
      lb_rx = v;
    end
  end

  // Behavioural slave, sample side: detects FS and captures bits on bit-clock fall.
  always @(negedge mcbsp_clk) begin
    fall_cnt++;
    if (fs === 1'b1) fs_falls_hi++;
    if (s_active) begin
      s_rx = {s_rx[FB-2:0], data_tx};
      s_cnt++;
      if (s_cnt == FB) begin
        s_active = 1'b0;
        slave_done++;
        if (slv_q.size() != 0) check("slave_rx", s_rx, slv_q.pop_front());
      end
    end else if (fs === 1'b1) begin
      s_active = 1'b1;
      s_cnt    = 0;
      s_tx_sh  = s_tx_word;
    end
  end

  // Behavioural slave, drive side: shifts its preloaded frame out on bit-clock rise.
  always @(posedge mcbsp_clk) begin
    if (s_active) begin
      s_out   = s_tx_sh[FB-1];
      s_tx_sh = {s_tx_sh[FB-2:0], 1'b0};
    end
  end

  task automatic pulse_start();
    host.start = 1'b1;
    @(posedge a_clk);
    #1;
    host.start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while (host.busy !== 1'b0 && n < budget) begin
      @(posedge a_clk);
      #1;
      n++;
    end
    check("idle_timeout", FB'(host.busy), FB'(0));
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge a_clk);
    #1;
  endtask

  initial begin
    #(500000);
    $display("FAIL watchdog: got no finish, required finish within budget");
    $fatal(1);
  end

  initial begin
    logic [FB-1:0] pat;
    int unsigned   base_a;
    int unsigned   base_b;
    int unsigned   base_c;
    int unsigned   n;

    a_reset      = 1'b1;
    host.start   = 1'b0;
    host.tx_data = '0;
    rx_sel       = 1'b0;
    s_tx_word    = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    s_tx_sh      = '0;
    s_rx         = '0;

    // 1: reset values, first bit-clock rise, flush length
    wait_cycles(3);
    check("rst_mcbsp_clk", FB'(mcbsp_clk), FB'(0));
    check("rst_fs", FB'(fs), FB'(0));
    check("rst_data_tx", FB'(data_tx), FB'(0));
    check("rst_dataset", host.dataset_read, FB'(0));
    check("rst_rx_valid", FB'(host.rx_valid), FB'(0));
    check("rst_overrun", FB'(host.overrun), FB'(0));
    check("rst_busy", FB'(host.busy), FB'(1));
    a_reset = 1'b0;
    base_a  = fall_cnt;
    wait_cycles(1);
    check("clk_low_1_after", FB'(mcbsp_clk), FB'(0));
    wait_cycles(1);
    check("clk_rise_2_after", FB'(mcbsp_clk), FB'(1));
    wait_idle(FRAME_BUD);
    check("flush_falls", FB'(fall_cnt - base_a), FB'(FB + TB_IDLE));

    // 2: loopback with tx_data changed while the frame is in flight
    pat = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h00000001,
           32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5};
    rx_sel = 1'b0;
    base_a = rx_cnt;
    exp_q.push_back(pat);
    host.tx_data = pat;
    pulse_start();
    check("busy_after_start", FB'(host.busy), FB'(1));
    wait_cycles(20);
    host.tx_data = ~pat;
    wait_idle(FRAME_BUD);
    check("lb_rx_pulses", FB'(rx_cnt - base_a), FB'(1));
    check("lb_q_empty", FB'(exp_q.size()), FB'(0));

    // 3: behavioural slave in both directions, frame sync width
    pat    = {32'hCAFEF00D, 32'h12345678, 32'h0F0F0F0F, 32'hF0F0F0F0,
              32'h00000003, 32'hC0000000, 32'h7FFFFFFE, 32'h5A5A5A5A};
    rx_sel = 1'b1;
    base_a = rx_cnt;
    base_b = slave_done;
    base_c = fs_falls_hi;
    exp_q.push_back(s_tx_word);
    slv_q.push_back(pat);
    host.tx_data = pat;
    pulse_start();
    wait_idle(FRAME_BUD);
    check("slv_rx_pulses", FB'(rx_cnt - base_a), FB'(1));
    check("slv_done", FB'(slave_done - base_b), FB'(1));
    check("slv_q_empty", FB'(slv_q.size()), FB'(0));
    check("fs_len_cycles", FB'(fs_len_last), FB'(4));
    check("fs_falls_spanned", FB'(fs_falls_hi - base_c), FB'(1));

    // 4: second start while busy is dropped and flagged
    pat    = rand_frame();
    rx_sel = 1'b0;
    base_a = rx_cnt;
    base_b = fs_rise_cnt;
    exp_q.push_back(pat);
    host.tx_data = pat;
    check("ovr_before", FB'(host.overrun), FB'(0));
    pulse_start();
    wait_cycles(9);
    host.tx_data = rand_frame();
    pulse_start();
    check("ovr_set", FB'(host.overrun), FB'(1));
    wait_idle(FRAME_BUD);
    check("ovr_sticky", FB'(host.overrun), FB'(1));
    wait_cycles(3 * BIT_CYC * 4);
    check("ovr_one_fs", FB'(fs_rise_cnt - base_b), FB'(1));
    check("ovr_one_rx", FB'(rx_cnt - base_a), FB'(1));
    check("ovr_stays_idle", FB'(host.busy), FB'(0));

    // 5: reset at bit ~100 discards the frame, flush blocks new requests
    host.tx_data = rand_frame();
    pulse_start();
    n = 0;
    while (fs !== 1'b1 && n < 16) begin
      wait_cycles(1);
      n++;
    end
    check("mid_fs_seen", FB'(fs), FB'(1));
    wait_cycles(100 * BIT_CYC);
    a_reset = 1'b1;
    wait_cycles(2);
    check("mid_rst_busy", FB'(host.busy), FB'(1));
    check("mid_rst_ovr_clr", FB'(host.overrun), FB'(0));
    check("mid_rst_fs", FB'(fs), FB'(0));
    a_reset = 1'b0;
    base_a  = rx_cnt;
    base_b  = fs_rise_cnt;
    wait_cycles(20);
    pulse_start();
    check("mid_start_ignored", FB'(host.overrun), FB'(1));
    wait_idle(FRAME_BUD);
    wait_cycles(10);
    check("mid_no_pending", FB'(host.busy), FB'(0));
    check("mid_no_fs", FB'(fs_rise_cnt - base_b), FB'(0));
    check("mid_no_rx", FB'(rx_cnt - base_a), FB'(0));
    pat = rand_frame();
    exp_q.push_back(pat);
    host.tx_data = pat;
    pulse_start();
    wait_idle(FRAME_BUD);
    check("mid_after_rx", FB'(rx_cnt - base_a), FB'(1));

    // 6: back-to-back request in the first idle cycle
    pat = rand_frame();
    exp_q.push_back(pat);
    host.tx_data = pat;
    pulse_start();
    n = 1;
    while (fs !== 1'b1 && n < 8) begin
      wait_cycles(1);
      n++;
    end
    check("b2b_fs_seen", FB'(fs), FB'(1));
    check("b2b_latency_le4", FB'(n <= 4), FB'(1));
    wait_idle(FRAME_BUD);
    check("b2b_rx", FB'(rx_cnt - base_a), FB'(2));
    check("final_q_empty", FB'(exp_q.size()), FB'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
